fifo_sync_ctl: RTL and testbench



---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_ram.sv | 48 ++++
 rtl/fifo_sync_ctl.sv | 132 +++++++++++++
 tb/tb_fifo_sync_ctl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - read-mode constants and parameter legality check for the sync FIFO
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic bit fifo_params_legal(int addr_width, int fwft, int af, int ae);
    int depth;
    depth = 1 << addr_width;
    return (fwft == FIFO_MODE_STD || fwft == FIFO_MODE_FWFT) &&
           (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port RAM, sync write, async or registered read
module fifo_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter bit ASYNC_READ = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  generate
    if (ASYNC_READ) begin : g_async
      logic unused_rd_ctl;
      assign unused_rd_ctl = reset ^ rd_en;
      assign rd_data = mem[rd_addr];
    end else begin : g_sync
      // Output register holds between reads and returns to zero on reset.
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

      always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = mem[rd_addr];
      end

      always_ff @(posedge clk) begin
        if (reset) rd_data_q <= '0;
        else       rd_data_q <= rd_data_d;
      end

      assign rd_data = rd_data_q;
    end
  endgenerate

endmodule

// File: rtl/fifo_sync_ctl.sv
// rtl/fifo_sync_ctl.sv - single-clock FIFO: pointers, count, flags, sticky errors
module fifo_sync_ctl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  clear_err,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_THRESH);

  generate
    if (!fifo_params_legal(ADDR_WIDTH, FWFT, AF_THRESH, AE_THRESH)) begin : g_bad_params
      $error("fifo_sync_ctl: FWFT, AF_THRESH or AE_THRESH out of legal range");
    end
  endgenerate

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic empty_q, empty_d, full_q, full_d, ae_q, ae_d, af_q, af_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic pop_ok, push_ok, wr_en, rd_en;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  always_comb begin
    pop_ok      = pop & ~empty_q;
    push_ok     = push & (~full_q | pop_ok);
    wr_en       = push_ok & ~flush;
    rd_en       = pop_ok & ~flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~clear_err;
    underflow_d = underflow_q & ~clear_err;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      if (push_ok && !pop_ok)      count_d = count_q + (ADDR_WIDTH+1)'(1);
      else if (pop_ok && !push_ok) count_d = count_q - (ADDR_WIDTH+1)'(1);
      // A new error outranks a simultaneous clear.
      if (push && !push_ok) overflow_d  = 1'b1;
      if (pop && !pop_ok)   underflow_d = 1'b1;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_CNT);
    ae_d    = (count_d <= AE_CNT);
    af_d    = (count_d >= AF_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      ae_q        <= 1'b1;
      af_q        <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      ae_q        <= ae_d;
      af_q        <= af_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ASYNC_READ (FWFT != FIFO_MODE_STD)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  generate
    if (FWFT != FIFO_MODE_STD) begin : g_fwft_out
      assign data_out = empty_q ? '0 : ram_rd_data;
    end else begin : g_std_out
      assign data_out = ram_rd_data;
    end
  endgenerate

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_ctl.sv
// tb/tb_fifo_sync_ctl.sv - standard and FWFT FIFO instances against a queue reference model
module tb_fifo_sync_ctl;

  logic clk = 1'b0;
  logic reset = 1'b1, flush = 1'b0, clear_err = 1'b0, push = 1'b0, pop = 1'b0;
  logic [63:0] data_in = '0;

  logic [63:0] s_dout, f_dout;
  logic s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
  logic f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [4:0] s_cnt, f_cnt;

  int n_checks = 0;
  int n_fail = 0;

  logic [63:0] m_q[$];
  logic [63:0] m_std_dout = '0;
  logic m_ovf = 1'b0, m_unf = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_ctl #(.FWFT(0)) u_std (
    .clk(clk), .reset(reset), .flush(flush), .clear_err(clear_err),
    .push(push), .data_in(data_in), .pop(pop), .data_out(s_dout),
    .empty(s_empty), .full(s_full), .almost_empty(s_ae), .almost_full(s_af),
    .fifo_count(s_cnt), .overflow(s_ovf), .underflow(s_unf)
  );

  fifo_sync_ctl #(.FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .flush(flush), .clear_err(clear_err),
    .push(push), .data_in(data_in), .pop(pop), .data_out(f_dout),
    .empty(f_empty), .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
    .fifo_count(f_cnt), .overflow(f_ovf), .underflow(f_unf)
  );

  // Drive one cycle of inputs, advance the reference model at the edge, sample 1 ns later.
  task automatic step(input logic r, input logic f, input logic ce,
                      input logic ps, input logic [63:0] d, input logic pp);
    bit pop_ok, push_ok;
    reset = r; flush = f; clear_err = ce; push = ps; data_in = d; pop = pp;
    @(posedge clk);
    if (r) begin
      m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_std_dout = '0;
    end else if (f) begin
      m_q.delete();
      if (ce) begin m_ovf = 1'b0; m_unf = 1'b0; end
    end else begin
      pop_ok  = pp && (m_q.size() != 0);
      push_ok = ps && ((m_q.size() < 16) || pop_ok);
      if (pop_ok)  m_std_dout = m_q.pop_front();
      if (push_ok) m_q.push_back(d);
      if (ce) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (ps && !push_ok) m_ovf = 1'b1;
      if (pp && !pop_ok)  m_unf = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, '0, 0);
    step(0, 0, 0, 0, '0, 0);
    n_checks++;
    if ({s_cnt, s_empty, s_full, s_ae, s_af, s_ovf, s_unf} !== 11'b00000_1_0_1_0_0_0) begin
      n_fail++; $display("FAIL reset_std_status: got %b expected 00000101000",
                         {s_cnt, s_empty, s_full, s_ae, s_af, s_ovf, s_unf});
    end
    n_checks++;
    if ({f_cnt, f_empty, f_full, f_ae, f_af, f_ovf, f_unf} !== 11'b00000_1_0_1_0_0_0) begin
      n_fail++; $display("FAIL reset_fwft_status: got %b expected 00000101000",
                         {f_cnt, f_empty, f_full, f_ae, f_af, f_ovf, f_unf});
    end
    n_checks++;
    if (s_dout !== 64'h0 || f_dout !== 64'h0) begin
      n_fail++; $display("FAIL reset_dout: got std=%0h fwft=%0h expected 0", s_dout, f_dout);
    end
  endtask

  task automatic test_fill_std();
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 0, 1, 64'(i), 0);
      if (i == 13 || i == 14) begin
        n_checks++;
        if (s_af !== (i == 14)) begin
          n_fail++; $display("FAIL fill_af_at_%0d: got %b expected %b", i, s_af, i == 14);
        end
      end
    end
    step(0, 0, 0, 1, 64'h11, 0);
    n_checks++;
    if (s_full !== 1'b1 || s_cnt !== 5'd16 || s_ovf !== 1'b1 || f_ovf !== 1'b1) begin
      n_fail++; $display("FAIL fill_overflow: got full=%b cnt=%0d ovf=%b/%b expected 1 16 1/1",
                         s_full, s_cnt, s_ovf, f_ovf);
    end
    for (int i = 1; i <= 16; i++) begin
      n_checks++;
      if (f_dout !== 64'(i)) begin
        n_fail++; $display("FAIL fill_fwft_head_%0d: got %0h expected %0h", i, f_dout, i);
      end
      step(0, 0, 0, 0, '0, 1);
      n_checks++;
      if (s_dout !== 64'(i)) begin
        n_fail++; $display("FAIL fill_std_pop_%0d: got %0h expected %0h", i, s_dout, i);
      end
    end
    n_checks++;
    if (s_empty !== 1'b1 || s_cnt !== 5'd0) begin
      n_fail++; $display("FAIL fill_drained: got empty=%b cnt=%0d expected 1 0", s_empty, s_cnt);
    end
    step(0, 0, 1, 0, '0, 0);
  endtask

  task automatic test_fwft_single();
    step(0, 0, 0, 1, 64'hAB, 0);
    n_checks++;
    if (f_empty !== 1'b0 || f_dout !== 64'hAB) begin
      n_fail++; $display("FAIL fwft_visible: got empty=%b dout=%0h expected 0 ab", f_empty, f_dout);
    end
    step(0, 0, 0, 0, '0, 1);
    n_checks++;
    if (f_empty !== 1'b1 || f_dout !== 64'h0) begin
      n_fail++; $display("FAIL fwft_popped: got empty=%b dout=%0h expected 1 0", f_empty, f_dout);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, {$urandom, $urandom}, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1, 64'hFF, 1);
      n_checks++;
      if (s_cnt !== 5'd16 || s_ovf !== 1'b0 || s_dout !== m_std_dout || f_dout !== m_q[0]) begin
        n_fail++; $display("FAIL full_pushpop_%0d: got cnt=%0d ovf=%b dout=%0h/%0h expected 16 0 %0h/%0h",
                           i, s_cnt, s_ovf, s_dout, f_dout, m_std_dout, m_q[0]);
      end
    end
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, '0, 1);
    n_checks++;
    if (s_dout !== 64'hFF || s_empty !== 1'b1) begin
      n_fail++; $display("FAIL full_wrap_tail: got dout=%0h empty=%b expected ff 1", s_dout, s_empty);
    end
  endtask

  task automatic test_empty_push_pop();
    step(0, 0, 0, 1, 64'h5, 1);
    n_checks++;
    if (s_cnt !== 5'd1 || s_unf !== 1'b1 || f_unf !== 1'b1) begin
      n_fail++; $display("FAIL empty_pushpop: got cnt=%0d unf=%b/%b expected 1 1/1", s_cnt, s_unf, f_unf);
    end
    step(0, 0, 1, 0, '0, 0);
    n_checks++;
    if (s_unf !== 1'b0 || f_unf !== 1'b0) begin
      n_fail++; $display("FAIL clear_err: got unf=%b/%b expected 0/0", s_unf, f_unf);
    end
    step(0, 0, 0, 0, '0, 1);
    n_checks++;
    if (s_dout !== 64'h5) begin
      n_fail++; $display("FAIL empty_pushpop_data: got %0h expected 5", s_dout);
    end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 64'(100 + i), 0);
    step(0, 1, 0, 1, 64'hDEAD, 1);
    n_checks++;
    if (s_cnt !== 5'd0 || s_empty !== 1'b1 || s_ae !== 1'b1 || s_dout !== 64'h5 ||
        s_ovf !== 1'b0 || s_unf !== 1'b0) begin
      n_fail++; $display("FAIL flush: got cnt=%0d empty=%b ae=%b dout=%0h err=%b%b expected 0 1 1 5 00",
                         s_cnt, s_empty, s_ae, s_dout, s_ovf, s_unf);
    end
    step(0, 0, 0, 1, 64'h77, 0);
    n_checks++;
    if (f_dout !== 64'h77 || f_cnt !== 5'd1) begin
      n_fail++; $display("FAIL flush_dropped: got head=%0h cnt=%0d expected 77 1", f_dout, f_cnt);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 64'(i), i[0]);
    step(0, 0, 0, 1, 64'h9, 1);
    step(1, 0, 0, 1, 64'hA, 1);
    n_checks++;
    if ({s_cnt, s_empty, s_full, s_ae, s_af, s_ovf, s_unf} !== 11'b00000_1_0_1_0_0_0 ||
        s_dout !== 64'h0 || f_dout !== 64'h0 || f_empty !== 1'b1) begin
      n_fail++; $display("FAIL midburst_reset: got %b dout=%0h/%0h expected 00000101000 0/0",
                         {s_cnt, s_empty, s_full, s_ae, s_af, s_ovf, s_unf}, s_dout, f_dout);
    end
  endtask

  task automatic test_random();
    logic [10:0] exp_stat;
    int bad = 0;
    step(0, 0, 0, 0, '0, 0);
    for (int i = 0; i < 10000; i++) begin
      // Bias toward fill or drain in phases so both full and empty corners are visited.
      int push_pct = ((i / 500) % 2 == 0) ? 70 : 30;
      step(0, ($urandom_range(0, 299) == 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 99) < push_pct), {$urandom, $urandom},
           ($urandom_range(0, 99) >= push_pct));
      exp_stat = {5'(m_q.size()), m_q.size() == 0, m_q.size() == 16,
                  m_q.size() <= 2, m_q.size() >= 14, m_ovf, m_unf};
      n_checks++;
      if ({s_cnt, s_empty, s_full, s_ae, s_af, s_ovf, s_unf} !== exp_stat ||
          {f_cnt, f_empty, f_full, f_ae, f_af, f_ovf, f_unf} !== exp_stat) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL rand_status_%0d: got std=%b fwft=%b expected %b", i,
                               {s_cnt, s_empty, s_full, s_ae, s_af, s_ovf, s_unf},
                               {f_cnt, f_empty, f_full, f_ae, f_af, f_ovf, f_unf}, exp_stat);
      end
      n_checks++;
      if (s_dout !== m_std_dout || f_dout !== ((m_q.size() != 0) ? m_q[0] : 64'h0)) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL rand_data_%0d: got std=%0h fwft=%0h expected std=%0h", i,
                               s_dout, f_dout, m_std_dout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_std();
    test_fwft_single();
    test_full_push_pop();
    test_empty_push_pop();
    test_flush_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
